pic_rx_packer: RTL

- Sits between the UART byte receiver and the PSRAM controller on the picture-upload path.
- Packs the received picture bytes into 32-bit words and gives each word an incrementing PSRAM word address.
- Buffers words in a small FIFO so that PSRAM write backpressure does not stall the UART.
- Pulses pic_rx_done to the state machine once a full frame has been written.

---
 rtl/pic_rx_packer_pkg.sv | 19 +
 rtl/pic_wr_fifo.sv | 57 +++++
 rtl/pic_rx_packer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pic_rx_packer_pkg.sv
// Shared types and constants for the picture-upload byte packer.
// Holds system state codes, frame geometry and the packer FSM encoding.
package pic_rx_packer_pkg;

  localparam logic [2:0] StateRxCode = 3'd1;
  localparam int unsigned PicWordsDefault = 393216;
  localparam int unsigned TimeoutDefault = 2700000;
  localparam int unsigned AddrWidth = 22;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned EntryWidth = AddrWidth + DataWidth;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrain,
    StDone
  } pic_fsm_e;

endpackage

// File: rtl/pic_wr_fifo.sv
// First-word fall-through write FIFO holding {addr, data} entries for the PSRAM side.
// A push into a full FIFO is accepted only if the head pops in the same cycle.
module pic_wr_fifo
  import pic_rx_packer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = EntryWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop_ok);
    end
  end

endmodule

// File: rtl/pic_rx_packer.sv
// Packs UART picture bytes big-endian into 32-bit words with incrementing PSRAM word
// addresses, buffers them for the PSRAM writer and pulses pic_rx_done per complete frame.
module pic_rx_packer
  import pic_rx_packer_pkg::*;
#(
  parameter int unsigned PIC_WORDS   = PicWordsDefault,
  parameter logic [2:0]  RX_CODE     = StateRxCode,
  parameter int unsigned TIMEOUT_CYC = TimeoutDefault,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_done,
  input  logic [2:0]  state,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [21:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        pic_rx_done,
  output logic        rx_err
);

  localparam logic [22:0] PicWordsW = 23'(PIC_WORDS);
  localparam logic [31:0] TimeoutW  = 32'(TIMEOUT_CYC);

  pic_fsm_e    fsm_q;
  logic [23:0] shift_q;
  logic [1:0]  byte_cnt_q;
  logic [22:0] word_cnt_q;
  logic [21:0] next_addr_q;
  logic [31:0] gap_q;
  logic        armed_q, rx_err_q, done_q;

  logic                  rx_sel, in_recv, abort, timeout, push, pop, flush, overflow;
  logic                  fifo_full, fifo_empty;
  logic [EntryWidth-1:0] fifo_rdata;

  assign rx_sel   = (state == RX_CODE);
  assign in_recv  = (fsm_q == StRecv);
  assign abort    = in_recv && !rx_sel;
  assign timeout  = in_recv && rx_sel && !uart_rx_done && (gap_q + 32'd1 == TimeoutW);
  assign push     = in_recv && rx_sel && uart_rx_done && (byte_cnt_q == 2'd3);
  assign pop      = wr_en && wr_ready;
  assign flush    = abort || timeout;
  // A full FIFO whose head leaves this cycle still has room for the new word.
  assign overflow = push && fifo_full && !pop;

  assign wr_en                = !fifo_empty;
  assign {wr_addr, wr_data}   = fifo_rdata;
  assign pic_rx_done          = done_q;
  assign rx_err               = rx_err_q;

  pic_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EntryWidth)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({next_addr_q, shift_q, uart_rx_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fsm_q       <= StIdle;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      next_addr_q <= '0;
      gap_q       <= '0;
      armed_q     <= 1'b1;
      rx_err_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (fsm_q)
        StIdle: begin
          if (rx_sel && armed_q) begin
            fsm_q       <= StRecv;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            next_addr_q <= '0;
            gap_q       <= '0;
            rx_err_q    <= 1'b0;
          end
        end
        StRecv: begin
          if (abort) begin
            fsm_q <= StIdle;
          end else if (timeout) begin
            rx_err_q <= 1'b1;
            fsm_q    <= StIdle;
          end else if (uart_rx_done) begin
            gap_q      <= '0;
            shift_q    <= {shift_q[15:0], uart_rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (push) begin
              // Dropped words still consume an address so later words stay aligned.
              word_cnt_q  <= word_cnt_q + 23'd1;
              next_addr_q <= next_addr_q + 22'd1;
              if (overflow) begin
                rx_err_q <= 1'b1;
              end
              if (word_cnt_q + 23'd1 == PicWordsW) begin
                fsm_q <= StDrain;
              end
            end
          end else begin
            gap_q <= gap_q + 32'd1;
          end
        end
        StDrain: begin
          if (fifo_empty) begin
            fsm_q  <= StDone;
            done_q <= 1'b1;
          end
        end
        StDone: begin
          fsm_q   <= StIdle;
          armed_q <= 1'b0;
        end
        default: fsm_q <= StIdle;
      endcase
      if (!rx_sel) begin
        armed_q <= 1'b1;
      end
    end
  end

endmodule
